// File: rtl/vx_wctl_agg_unit.sv
// ---------------------------------------------------------------------------
// vx_wctl_agg_unit
//   Warp-control aggregator for SFU wctl ops when a warp arrives as several
//   packets (NUM_LANES < NUM_THREADS). Per-packet branch conditions are merged
//   into full-warp then/else masks, tracked independently per warp. At the
//   last packet the op (TMC/PRED/SPLIT/JOIN) is resolved and the result is
//   queued in a DEPTH-entry in-order FIFO that drains to the warp scheduler.
//
// Handshake: a transfer happens on a port exactly in the cycle where its
//   valid and ready are both high at the rising clock edge. A producer holds
//   its payload stable while valid is high and ready is low; out_* are
//   driven from FIFO storage and so stay stable while stalled.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   in_valid_i/in_ready_o   packet handshake; in_ready_o = FIFO not full
//   in_wid_i, in_pid_i      warp id, packet index within the warp
//   in_sop_i, in_eop_i      first / last packet of the instruction
//   in_op_i                 0 TMC, 1 PRED, 2 SPLIT, 3 JOIN
//   in_neg_i                invert the branch condition
//   in_tmask_i, in_cond_i   active lanes / rs1[0] per lane of this packet
//   in_alt_mask_i, in_pc_i  TMC/PRED mask and PC, used at the last packet
//   out_valid_o/out_ready_i request handshake toward the scheduler
//   out_wid_o, out_op_o     warp id / op of the request
//   out_then_tmask_o        TMC/PRED/JOIN mask, SPLIT first-path mask
//   out_else_tmask_o        SPLIT second-path mask, 0 otherwise
//   out_is_dvg_o            SPLIT with both sides non-empty
//   out_next_pc_o           in_pc+4 for SPLIT, 0 otherwise
//   err_seq_o               one-cycle pulse after a packet-sequence violation
//   dbg_accum_o             per-warp FSM state (1 = ACCUM)
// ---------------------------------------------------------------------------
module vx_wctl_agg_unit #(
   parameter int NUM_WARPS    = 4,
   parameter int NUM_THREADS  = 4,
   parameter int NUM_LANES    = 4,
   parameter int DEPTH        = 2,
   parameter int PC_W         = 32,
   parameter int SPLIT_POLICY = 0,
   localparam int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   localparam int NUM_PKTS    = NUM_THREADS / NUM_LANES,
   localparam int PID_W       = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   in_valid_i,
   output logic                   in_ready_o,
   input  logic [NW_BITS-1:0]     in_wid_i,
   input  logic [PID_W-1:0]       in_pid_i,
   input  logic                   in_sop_i,
   input  logic                   in_eop_i,
   input  logic [1:0]             in_op_i,
   input  logic                   in_neg_i,
   input  logic [NUM_LANES-1:0]   in_tmask_i,
   input  logic [NUM_LANES-1:0]   in_cond_i,
   input  logic [NUM_THREADS-1:0] in_alt_mask_i,
   input  logic [PC_W-1:0]        in_pc_i,
   output logic                   out_valid_o,
   input  logic                   out_ready_i,
   output logic [NW_BITS-1:0]     out_wid_o,
   output logic [1:0]             out_op_o,
   output logic [NUM_THREADS-1:0] out_then_tmask_o,
   output logic [NUM_THREADS-1:0] out_else_tmask_o,
   output logic                   out_is_dvg_o,
   output logic [PC_W-1:0]        out_next_pc_o,
   output logic                   err_seq_o,
   output logic [NUM_WARPS-1:0]   dbg_accum_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int POP_W = $clog2(NUM_THREADS + 1);

   localparam logic [1:0] OP_TMC   = 2'd0;
   localparam logic [1:0] OP_PRED  = 2'd1;
   localparam logic [1:0] OP_SPLIT = 2'd2;
   localparam logic [1:0] OP_JOIN  = 2'd3;

   typedef enum logic {
      W_IDLE  = 1'b0,
      W_ACCUM = 1'b1
   } wstate_e;

   typedef struct packed {
      logic [NW_BITS-1:0]     wid;
      logic [1:0]             op;
      logic [NUM_THREADS-1:0] then_m;
      logic [NUM_THREADS-1:0] else_m;
      logic                   dvg;
      logic [PC_W-1:0]        npc;
   } entry_t;

   function automatic logic [POP_W-1:0] popcnt(input logic [NUM_THREADS-1:0] v);
      logic [POP_W-1:0] c;
      c = '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
         c = c + POP_W'(v[i]);
      end
      return c;
   endfunction

   // Per-warp state and mask tables
   wstate_e                wstate_q [NUM_WARPS];
   wstate_e                wstate_d [NUM_WARPS];
   logic [PID_W-1:0]       last_pid_q [NUM_WARPS];
   logic [NUM_THREADS-1:0] then_q [NUM_WARPS];
   logic [NUM_THREADS-1:0] else_q [NUM_WARPS];

   // Output FIFO
   entry_t                 fifo_mem_q [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   err_seq_q, err_seq_d;

   logic                   accept, pid_ok, tbl_wr, push, pop, viol, fifo_full;
   wstate_e                cur_state;
   logic [NUM_LANES-1:0]   taken, then_p, else_p;
   logic [NUM_THREADS-1:0] m_then, m_else;
   logic                   has_then, has_else;
   entry_t                 push_entry;

   assign fifo_full  = (count_q == CNT_W'(DEPTH));
   assign in_ready_o = !fifo_full;
   assign accept     = in_valid_i && in_ready_o;
   assign pop        = out_valid_o && out_ready_i;

   // ---------------- packet classification and merge ----------------
   always_comb begin
      cur_state = wstate_q[in_wid_i];
      pid_ok    = (in_pid_i > last_pid_q[in_wid_i]);
      taken     = in_cond_i ^ {NUM_LANES{in_neg_i}};
      then_p    = taken & in_tmask_i;
      else_p    = ~taken & in_tmask_i;

      m_then = in_sop_i ? '0 : then_q[in_wid_i];
      m_else = in_sop_i ? '0 : else_q[in_wid_i];
      for (int p = 0; p < NUM_PKTS; p++) begin
         if (int'(in_pid_i) == p) begin
            m_then[p*NUM_LANES +: NUM_LANES] = then_p;
            m_else[p*NUM_LANES +: NUM_LANES] = else_p;
         end
      end

      // A sop always (re)starts accumulation, including the restart-on-violation
      // case where the warp was already in ACCUM.
      tbl_wr = accept && !in_eop_i && (in_sop_i || (cur_state == W_ACCUM && pid_ok));
      push   = accept && in_eop_i &&
               (in_sop_i ? (cur_state == W_IDLE) : (cur_state == W_ACCUM && pid_ok));
      viol   = accept &&
               (in_sop_i ? (cur_state == W_ACCUM) : !(cur_state == W_ACCUM && pid_ok));
   end

   // ---------------- per-warp FSM next state ----------------
   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         wstate_d[w] = wstate_q[w];
      end
      if (accept) begin
         wstate_d[in_wid_i] = tbl_wr ? W_ACCUM : W_IDLE;
      end
      for (int w = 0; w < NUM_WARPS; w++) begin
         dbg_accum_o[w] = (wstate_q[w] == W_ACCUM);
      end
   end

   // ---------------- resolve at end of packet ----------------
   always_comb begin
      has_then          = |m_then;
      has_else          = |m_else;
      push_entry        = '0;
      push_entry.wid    = in_wid_i;
      push_entry.op     = in_op_i;
      case (in_op_i)
         OP_TMC:  push_entry.then_m = in_alt_mask_i;
         OP_PRED: push_entry.then_m = has_then ? m_then : in_alt_mask_i;
         OP_JOIN: push_entry.then_m = m_then | m_else;
         OP_SPLIT: begin
            // Fewer-active side runs first so the reconvergence stack stays shallow;
            // a tie keeps the then side first.
            if (SPLIT_POLICY == 0 && popcnt(m_else) < popcnt(m_then)) begin
               push_entry.then_m = m_else;
               push_entry.else_m = m_then;
            end else begin
               push_entry.then_m = m_then;
               push_entry.else_m = m_else;
            end
            push_entry.dvg = has_then && has_else;
            push_entry.npc = in_pc_i + PC_W'(4);
         end
         default: push_entry.then_m = '0;
      endcase
   end

   // ---------------- FIFO control ----------------
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      err_seq_d = viol;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int w = 0; w < NUM_WARPS; w++) begin
            wstate_q[w] <= W_IDLE;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         err_seq_q <= 1'b0;
      end else begin
         wstate_q  <= wstate_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         err_seq_q <= err_seq_d;
      end
   end

   // Table and FIFO storage carry no reset; they are only read once validated
   // by the FSM state or the FIFO count.
   always_ff @(posedge clk_i) begin
      if (tbl_wr) begin
         then_q[in_wid_i]     <= m_then;
         else_q[in_wid_i]     <= m_else;
         last_pid_q[in_wid_i] <= in_pid_i;
      end
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= push_entry;
      end
   end

   // ---------------- outputs ----------------
   assign out_valid_o      = (count_q != '0);
   assign out_wid_o        = fifo_mem_q[rd_ptr_q].wid;
   assign out_op_o         = fifo_mem_q[rd_ptr_q].op;
   assign out_then_tmask_o = fifo_mem_q[rd_ptr_q].then_m;
   assign out_else_tmask_o = fifo_mem_q[rd_ptr_q].else_m;
   assign out_is_dvg_o     = fifo_mem_q[rd_ptr_q].dvg;
   assign out_next_pc_o    = fifo_mem_q[rd_ptr_q].npc;
   assign err_seq_o        = err_seq_q;

endmodule

// File: tb/tb_vx_wctl_agg_unit.sv
// Directed bench for vx_wctl_agg_unit with 4 threads split into 2-lane packets.
module tb_vx_wctl_agg_unit;

   localparam int EW = 45;  // {wid 2, op 2, then 4, else 4, dvg 1, npc 32}

   localparam logic [1:0] TMC   = 2'd0;
   localparam logic [1:0] PRED  = 2'd1;
   localparam logic [1:0] SPLIT = 2'd2;
   localparam logic [1:0] JOIN  = 2'd3;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, in_sop, in_eop, in_neg, in_pid;
   logic [1:0]  in_wid, in_op, in_tmask, in_cond;
   logic [3:0]  in_alt_mask;
   logic [31:0] in_pc;
   logic        out_valid, out_ready, out_is_dvg, err_seq;
   logic [1:0]  out_wid, out_op;
   logic [3:0]  out_then_tmask, out_else_tmask, dbg_accum;
   logic [31:0] out_next_pc;

   vx_wctl_agg_unit #(
      .NUM_WARPS(4), .NUM_THREADS(4), .NUM_LANES(2), .DEPTH(2), .PC_W(32), .SPLIT_POLICY(0)
   ) dut (
      .clk_i(clk), .reset_i(reset),
      .in_valid_i(in_valid), .in_ready_o(in_ready),
      .in_wid_i(in_wid), .in_pid_i(in_pid), .in_sop_i(in_sop), .in_eop_i(in_eop),
      .in_op_i(in_op), .in_neg_i(in_neg), .in_tmask_i(in_tmask), .in_cond_i(in_cond),
      .in_alt_mask_i(in_alt_mask), .in_pc_i(in_pc),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_wid_o(out_wid), .out_op_o(out_op),
      .out_then_tmask_o(out_then_tmask), .out_else_tmask_o(out_else_tmask),
      .out_is_dvg_o(out_is_dvg), .out_next_pc_o(out_next_pc),
      .err_seq_o(err_seq), .dbg_accum_o(dbg_accum)
   );

   // ---------------- scoreboard ----------------
   int             checks = 0;
   int             errors = 0;
   logic [EW-1:0]  exp_q[$];
   logic [EW-1:0]  mon_e;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [EW-1:0] mk(input logic [1:0] wid, input logic [1:0] op,
                                        input logic [3:0] th, input logic [3:0] el,
                                        input logic dvg, input logic [31:0] npc);
      return {wid, op, th, el, dvg, npc};
   endfunction

   // Output monitor: a transfer is committed at the next posedge, so compare at negedge.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_out observed=%0h expected=none",
                   {out_wid, out_op, out_then_tmask, out_else_tmask, out_is_dvg, out_next_pc});
         end
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("out_pkt",
                64'({out_wid, out_op, out_then_tmask, out_else_tmask, out_is_dvg, out_next_pc}),
                64'(mon_e));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic drive(input logic [1:0] wid, input logic pid, input logic sop, input logic eop,
                        input logic [1:0] op, input logic neg, input logic [1:0] tm,
                        input logic [1:0] cond, input logic [3:0] alt, input logic [31:0] pc);
      in_wid = wid; in_pid = pid; in_sop = sop; in_eop = eop; in_op = op;
      in_neg = neg; in_tmask = tm; in_cond = cond; in_alt_mask = alt; in_pc = pc;
      in_valid = 1'b1;
   endtask

   // Returns #1 after the accepting clock edge.
   task automatic send(input logic [1:0] wid, input logic pid, input logic sop, input logic eop,
                       input logic [1:0] op, input logic neg, input logic [1:0] tm,
                       input logic [1:0] cond, input logic [3:0] alt, input logic [31:0] pc);
      int n;
      drive(wid, pid, sop, eop, op, neg, tm, cond, alt, pc);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (n >= 20) chk("in_ready_timeout", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 50; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      chk("drain", 64'(exp_q.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      out_ready = 1'b1;
      drive(2'd0, 1'b0, 1'b0, 1'b0, TMC, 1'b0, 2'b00, 2'b00, 4'h0, 32'h0);
      in_valid = 1'b0;
      do_reset();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_err_seq",   64'(err_seq),   64'(0));
      chk("rst_in_ready",  64'(in_ready),  64'(1));
      chk("rst_dbg",       64'(dbg_accum), 64'(0));

      // SPLIT w1 over two packets: then=0010 else=1101, diverged.
      send(2'd1, 1'b0, 1'b1, 1'b0, SPLIT, 1'b0, 2'b11, 2'b10, 4'h0, 32'h100);
      chk("split_accum_state", 64'(dbg_accum), 64'(4'b0010));
      chk("split_no_out_yet",  64'(out_valid), 64'(0));
      exp_q.push_back(mk(2'd1, SPLIT, 4'b0010, 4'b1101, 1'b1, 32'h104));
      send(2'd1, 1'b1, 1'b0, 1'b1, SPLIT, 1'b0, 2'b11, 2'b00, 4'h0, 32'h100);
      chk("split_latency", 64'(out_valid), 64'(1));
      chk("split_err",     64'(err_seq),   64'(0));
      chk("split_idle",    64'(dbg_accum), 64'(0));
      wait_drain();

      // PRED: empty then side falls back to the alt mask.
      exp_q.push_back(mk(2'd0, PRED, 4'b0101, 4'b0000, 1'b0, 32'h0));
      send(2'd0, 1'b0, 1'b1, 1'b1, PRED, 1'b0, 2'b11, 2'b00, 4'b0101, 32'h40);
      // PRED over two packets with a taken half.
      send(2'd0, 1'b0, 1'b1, 1'b0, PRED, 1'b0, 2'b11, 2'b11, 4'b1000, 32'h40);
      exp_q.push_back(mk(2'd0, PRED, 4'b0011, 4'b0000, 1'b0, 32'h0));
      send(2'd0, 1'b1, 1'b0, 1'b1, PRED, 1'b0, 2'b11, 2'b00, 4'b1000, 32'h40);
      // PRED with negation, single packet at pid1 (pid0 skipped).
      exp_q.push_back(mk(2'd0, PRED, 4'b0100, 4'b0000, 1'b0, 32'h0));
      send(2'd0, 1'b1, 1'b1, 1'b1, PRED, 1'b1, 2'b11, 2'b10, 4'b1111, 32'h40);
      wait_drain();

      // JOIN w2 with an empty final packet: union of both sides.
      send(2'd2, 1'b0, 1'b1, 1'b0, JOIN, 1'b0, 2'b11, 2'b01, 4'h0, 32'h80);
      exp_q.push_back(mk(2'd2, JOIN, 4'b0011, 4'b0000, 1'b0, 32'h0));
      send(2'd2, 1'b1, 1'b0, 1'b1, JOIN, 1'b0, 2'b00, 2'b00, 4'h0, 32'h80);
      // TMC w3 takes the alt mask as-is.
      exp_q.push_back(mk(2'd3, TMC, 4'b1010, 4'b0000, 1'b0, 32'h0));
      send(2'd3, 1'b0, 1'b1, 1'b1, TMC, 1'b0, 2'b11, 2'b11, 4'b1010, 32'h80);
      wait_drain();

      // SPLIT ordering: tie keeps then first.
      exp_q.push_back(mk(2'd0, SPLIT, 4'b0001, 4'b0010, 1'b1, 32'h14));
      send(2'd0, 1'b0, 1'b1, 1'b1, SPLIT, 1'b0, 2'b11, 2'b01, 4'h0, 32'h10);
      // Larger then side goes second; PC wraps.
      send(2'd1, 1'b0, 1'b1, 1'b0, SPLIT, 1'b0, 2'b11, 2'b11, 4'h0, 32'hFFFF_FFFE);
      exp_q.push_back(mk(2'd1, SPLIT, 4'b1000, 4'b0111, 1'b1, 32'h0000_0002));
      send(2'd1, 1'b1, 1'b0, 1'b1, SPLIT, 1'b0, 2'b11, 2'b01, 4'h0, 32'hFFFF_FFFE);
      // Not diverged: empty then side still first.
      exp_q.push_back(mk(2'd2, SPLIT, 4'b0000, 4'b0011, 1'b0, 32'h24));
      send(2'd2, 1'b0, 1'b1, 1'b1, SPLIT, 1'b0, 2'b11, 2'b00, 4'h0, 32'h20);
      wait_drain();

      // Backpressure: two entries fill the FIFO, third waits for one pop.
      out_ready = 1'b0;
      exp_q.push_back(mk(2'd0, TMC, 4'b0001, 4'b0000, 1'b0, 32'h0));
      exp_q.push_back(mk(2'd1, TMC, 4'b0010, 4'b0000, 1'b0, 32'h0));
      exp_q.push_back(mk(2'd2, TMC, 4'b0100, 4'b0000, 1'b0, 32'h0));
      send(2'd0, 1'b0, 1'b1, 1'b1, TMC, 1'b0, 2'b11, 2'b00, 4'b0001, 32'h0);
      send(2'd1, 1'b0, 1'b1, 1'b1, TMC, 1'b0, 2'b11, 2'b00, 4'b0010, 32'h0);
      chk("bp_full_ready", 64'(in_ready), 64'(0));
      drive(2'd2, 1'b0, 1'b1, 1'b1, TMC, 1'b0, 2'b11, 2'b00, 4'b0100, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_hold_ready", 64'(in_ready),       64'(0));
      chk("bp_hold_valid", 64'(out_valid),      64'(1));
      chk("bp_hold_then",  64'(out_then_tmask), 64'(4'b0001));
      chk("bp_hold_wid",   64'(out_wid),        64'(0));
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      chk("bp_one_pop_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("bp_refull_ready", 64'(in_ready), 64'(0));
      out_ready = 1'b1;
      wait_drain();

      // Violation: non-sop packet while IDLE is dropped.
      send(2'd3, 1'b1, 1'b0, 1'b1, TMC, 1'b0, 2'b11, 2'b11, 4'b1100, 32'h0);
      chk("viol_idle_err",   64'(err_seq),   64'(1));
      chk("viol_idle_nopush", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      chk("viol_err_pulse",  64'(err_seq),   64'(0));
      exp_q.push_back(mk(2'd3, TMC, 4'b1111, 4'b0000, 1'b0, 32'h0));
      send(2'd3, 1'b0, 1'b1, 1'b1, TMC, 1'b0, 2'b11, 2'b11, 4'b1111, 32'h0);
      chk("viol_recover_err", 64'(err_seq), 64'(0));
      wait_drain();

      // Violation: repeated pid drops the packet and idles the warp.
      send(2'd1, 1'b1, 1'b1, 1'b0, SPLIT, 1'b0, 2'b11, 2'b11, 4'h0, 32'h0);
      send(2'd1, 1'b1, 1'b0, 1'b1, SPLIT, 1'b0, 2'b11, 2'b11, 4'h0, 32'h0);
      chk("viol_pid_err",  64'(err_seq),   64'(1));
      chk("viol_pid_idle", 64'(dbg_accum), 64'(0));
      chk("viol_pid_nopush", 64'(out_valid), 64'(0));

      // Violation: sop while ACCUM restarts with the new packet.
      send(2'd2, 1'b0, 1'b1, 1'b0, SPLIT, 1'b0, 2'b11, 2'b11, 4'h0, 32'h300);
      send(2'd2, 1'b0, 1'b1, 1'b0, SPLIT, 1'b0, 2'b11, 2'b00, 4'h0, 32'h300);
      chk("viol_sop_err",   64'(err_seq),   64'(1));
      chk("viol_sop_accum", 64'(dbg_accum), 64'(4'b0100));
      exp_q.push_back(mk(2'd2, SPLIT, 4'b0000, 4'b1111, 1'b0, 32'h304));
      send(2'd2, 1'b1, 1'b0, 1'b1, SPLIT, 1'b0, 2'b11, 2'b00, 4'h0, 32'h300);
      wait_drain();

      // Interleaved warps keep independent masks.
      send(2'd0, 1'b0, 1'b1, 1'b0, SPLIT, 1'b0, 2'b11, 2'b10, 4'h0, 32'h200);
      exp_q.push_back(mk(2'd1, TMC, 4'b0110, 4'b0000, 1'b0, 32'h0));
      send(2'd1, 1'b0, 1'b1, 1'b1, TMC, 1'b0, 2'b11, 2'b00, 4'b0110, 32'h0);
      exp_q.push_back(mk(2'd0, SPLIT, 4'b0001, 4'b1110, 1'b1, 32'h204));
      send(2'd0, 1'b1, 1'b0, 1'b1, SPLIT, 1'b0, 2'b11, 2'b11, 4'h0, 32'h200);
      wait_drain();

      // Reset mid-sequence discards the FIFO and partial warp state.
      out_ready = 1'b0;
      send(2'd2, 1'b0, 1'b1, 1'b1, TMC, 1'b0, 2'b11, 2'b00, 4'b1001, 32'h0);
      send(2'd0, 1'b0, 1'b1, 1'b0, JOIN, 1'b0, 2'b11, 2'b01, 4'h0, 32'h0);
      chk("pre_rst_valid", 64'(out_valid), 64'(1));
      chk("pre_rst_dbg",   64'(dbg_accum), 64'(4'b0001));
      do_reset();
      chk("mid_rst_valid", 64'(out_valid), 64'(0));
      chk("mid_rst_dbg",   64'(dbg_accum), 64'(0));
      out_ready = 1'b1;
      send(2'd0, 1'b1, 1'b0, 1'b1, JOIN, 1'b0, 2'b11, 2'b11, 4'h0, 32'h0);
      chk("mid_rst_err",    64'(err_seq),   64'(1));
      chk("mid_rst_nopush", 64'(out_valid), 64'(0));
      repeat (3) @(posedge clk);
      #1;
      chk("mid_rst_empty",  64'(out_valid), 64'(0));
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
